// File: rtl/iter_sub_box_layer.sv
// Iterative forward substitution layer: applies the 4-bit sub_box to all 32
// nibbles of a 128-bit word, NPC nibbles per clock, with valid/ready on both sides.

module sub_box (
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);
  always_comb begin
    nib_out = 4'h0;
    unique case (nib_in)
      4'h0: nib_out = 4'hC;
      4'h1: nib_out = 4'h5;
      4'h2: nib_out = 4'h6;
      4'h3: nib_out = 4'hB;
      4'h4: nib_out = 4'h9;
      4'h5: nib_out = 4'h0;
      4'h6: nib_out = 4'hA;
      4'h7: nib_out = 4'hD;
      4'h8: nib_out = 4'h3;
      4'h9: nib_out = 4'hE;
      4'hA: nib_out = 4'hF;
      4'hB: nib_out = 4'h8;
      4'hC: nib_out = 4'h4;
      4'hD: nib_out = 4'h7;
      4'hE: nib_out = 4'h1;
      4'hF: nib_out = 4'h2;
      default: nib_out = 4'h0;
    endcase
  end
endmodule

// state | meaning
// IDLE  | waiting for a word; in_ready=1
// BUSY  | substituting NPC nibbles per cycle and rotating right
// DONE  | result held on data_out until out_ready
module iter_sub_box_layer #(
  parameter int NPC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);
  localparam int STEPS = 32 / NPC;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEPS - 1);

  if (NPC < 1 || NPC > 32 || (32 % NPC) != 0) begin : g_bad_npc
    $error("iter_sub_box_layer: NPC must divide 32");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [127:0]  work_q, work_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4*NPC-1:0] sub_out;
  logic [127:0]  rot;

  for (genvar g = 0; g < NPC; g++) begin : g_sbox
    sub_box u_sbox (
      .nib_in (work_q[4*g+3:4*g]),
      .nib_out(sub_out[4*g+3:4*g])
    );
  end

  // Substituted low slice re-enters at the top, so after STEPS cycles every
  // nibble is back in its original position.
  if (NPC == 32) begin : g_rot_full
    assign rot = sub_out;
  end else begin : g_rot_part
    assign rot = {sub_out, work_q[127:4*NPC]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = data_in;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        work_d = rot;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        // Handoff and reload share one edge so a streaming source sees no bubble.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            work_d  = data_in;
            cnt_d   = '0;
            state_d = S_BUSY;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data_out = work_q;
  assign busy     = (state_q == S_BUSY);

endmodule

// File: tb/tb_iter_sub_box_layer.sv
// Directed bench for iter_sub_box_layer: one DUT per NPC value, scoreboard queue
// of model results, immediate assertions at every comparison.

module tb_iter_sub_box_layer;
  localparam int NI = 5;
  localparam int NPCS [NI] = '{4, 1, 2, 8, 32};
  localparam logic [127:0] W3 = 128'h0123456789ABCDEFFEDCBA9876543210;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid [NI];
  logic in_ready [NI];
  logic out_valid [NI];
  logic out_ready [NI];
  logic busy [NI];
  logic [127:0] data_in [NI];
  logic [127:0] data_out [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    iter_sub_box_layer #(.NPC(NPCS[g])) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .data_in  (data_in[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .data_out (data_out[g]),
      .busy     (busy[g])
    );
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] exp_q [$];

  function automatic logic [3:0] sb_model(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h2174_8FE3_DA09_B65C;
    return tbl[4*x +: 4];
  endfunction

  function automatic logic [127:0] layer_model(input logic [127:0] w);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[4*i +: 4] = sb_model(w[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [127:0] inv_layer(input logic [127:0] w);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      for (int v = 0; v < 16; v++)
        if (sb_model(4'(v)) == w[4*i +: 4]) r[4*i +: 4] = 4'(v);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input int k, input logic [127:0] w);
    @(negedge clk);
    data_in[k]  = w;
    in_valid[k] = 1'b1;
    #1;
    chk("accept_ready", 128'(in_ready[k]), 128'd1);
    @(posedge clk);
    exp_q.push_back(layer_model(w));
    #1;
    in_valid[k] = 1'b0;
  endtask

  // Leaves the bench at the negedge where out_valid was first seen.
  task automatic wait_out(input int k, input int steps, input string tag);
    int lat;
    lat = -1;
    for (int t = 0; t <= 200; t++) begin
      @(negedge clk);
      if (out_valid[k]) begin
        lat = t;
        break;
      end
    end
    chk({tag, "_latency"}, 128'(lat), 128'(steps));
    chk({tag, "_busy_low"}, 128'(busy[k]), 128'd0);
    if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 128'd1, 128'd0);
    else chk({tag, "_data"}, data_out[k], exp_q.pop_front());
  endtask

  task automatic hand_off(input int k);
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[k] = 1'b0;
    @(negedge clk);
    chk("handoff_out_valid", 128'(out_valid[k]), 128'd0);
    chk("handoff_in_ready", 128'(in_ready[k]), 128'd1);
  endtask

  initial begin
    logic [127:0] words [10];
    logic [127:0] wa, wb;
    int sent, got, last_c;

    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      data_in[k]   = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready[0]), 128'd1);
    chk("rst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("rst_busy", 128'(busy[0]), 128'd0);
    chk("rst_data_out", data_out[0], 128'd0);
    rst_n = 1'b1;

    // reset while BUSY with cnt=3
    send(0, W3);
    repeat (4) @(negedge clk);
    chk("t1_busy_before", 128'(busy[0]), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_out_valid", 128'(out_valid[0]), 128'd0);
    chk("t1_in_ready", 128'(in_ready[0]), 128'd1);
    chk("t1_data_out", data_out[0], 128'd0);
    chk("t1_busy", 128'(busy[0]), 128'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(0, W3);
    wait_out(0, 8, "t1_next");
    hand_off(0);

    send(0, 128'h0);
    wait_out(0, 8, "t2");
    chk("t2_all_c", data_out[0], {32{4'hC}});
    hand_off(0);

    send(0, W3);
    wait_out(0, 8, "t3");
    chk("t3_inverse", inv_layer(data_out[0]), W3);
    hand_off(0);

    // back-pressure in DONE with a word offered
    wa = {$urandom, $urandom, $urandom, $urandom};
    wb = {$urandom, $urandom, $urandom, $urandom};
    send(0, wa);
    wait_out(0, 8, "t4_a");
    data_in[0]  = wb;
    in_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t4_hold_data", data_out[0], layer_model(wa));
      chk("t4_hold_in_ready", 128'(in_ready[0]), 128'd0);
      chk("t4_hold_out_valid", 128'(out_valid[0]), 128'd1);
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    #1;
    chk("t4_release_in_ready", 128'(in_ready[0]), 128'd1);
    @(posedge clk);
    exp_q.push_back(layer_model(wb));
    #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    wait_out(0, 8, "t4_b");
    hand_off(0);

    // streaming: source and sink always willing
    for (int i = 0; i < 10; i++) words[i] = {$urandom, $urandom, $urandom, $urandom};
    sent = 0;
    got = 0;
    last_c = 0;
    out_ready[0] = 1'b1;
    for (int c = 0; c < 300 && got < 10; c++) begin
      @(negedge clk);
      if (sent < 10) begin
        data_in[0]  = words[sent];
        in_valid[0] = 1'b1;
      end else begin
        in_valid[0] = 1'b0;
      end
      #1;
      if (out_valid[0]) begin
        if (exp_q.size() == 0) chk("t5_sb_empty", 128'd1, 128'd0);
        else chk("t5_data", data_out[0], exp_q.pop_front());
        if (got > 0) chk("t5_period", 128'(c - last_c), 128'd9);
        last_c = c;
        got++;
      end
      if (in_valid[0] && in_ready[0]) begin
        exp_q.push_back(layer_model(words[sent]));
        sent++;
      end
    end
    chk("t5_count", 128'(got), 128'd10);
    @(posedge clk);
    #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    exp_q.delete();

    for (int k = 1; k < NI; k++) begin
      send(k, W3);
      wait_out(k, 32 / NPCS[k], $sformatf("t6_npc%0d", NPCS[k]));
      hand_off(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
